subleq_run_ctrl: RTL

//  Run/load controller for the single-bus SUBLEQ core. Owns the core's reset and cpu_en.

---
 rtl/subleq_run_ctrl_pkg.sv | 18 +
 rtl/subleq_phase_tracker.sv | 49 ++++
 rtl/subleq_run_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/subleq_run_ctrl_pkg.sv
// Shared types and constants for the SUBLEQ run/load controller.
package subleq_run_ctrl_pkg;

    localparam int BUS_W   = 32;
    localparam int PHASE_W = 3;

    localparam logic [PHASE_W-1:0] PHASE_FETCH = 3'd0;
    localparam logic [PHASE_W-1:0] PHASE_LAST  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HACC = 3'd1,
        ST_HACK = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/subleq_phase_tracker.sv
// Mod-6 instruction phase counter plus a saturating retired-instruction counter.
module subleq_phase_tracker
    import subleq_run_ctrl_pkg::*;
#(
    parameter int MAX_INSTR = 1_000_000,
    parameter int CNT_W     = $clog2(MAX_INSTR + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic [CNT_W-1:0]   instr_cnt_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            phase_d = PHASE_FETCH;
            cnt_d   = '0;
        end else if (en_i) begin
            if (phase_q == PHASE_LAST) begin
                phase_d = PHASE_FETCH;
                if (cnt_q != CNT_W'(MAX_INSTR))
                    cnt_d = cnt_q + 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PHASE_FETCH;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign phase_o     = phase_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: rtl/subleq_run_ctrl.sv
// Run/load controller: owns core reset and bus ownership, serves host accesses
// while the core is stopped, and ends a run on halt PC, budget or abort.
module subleq_run_ctrl
    import subleq_run_ctrl_pkg::*;
#(
    parameter logic [BUS_W-1:0] HALT_PC   = 32'hFFFF_FFF4,
    parameter int               MAX_INSTR = 1_000_000,
    parameter int               CNT_W     = $clog2(MAX_INSTR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [BUS_W-1:0] host_addr,
    input  logic [BUS_W-1:0] host_wdata,
    output logic [BUS_W-1:0] host_rdata,
    output logic             host_ack,
    output logic             core_rst,
    output logic             cpu_en,
    inout  wire              mem_we,
    inout  wire  [BUS_W-1:0] mem_addr,
    inout  wire  [BUS_W-1:0] mem_data,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e             state_q;
    logic               core_rst_q, cpu_en_q, host_ack_q, done_q;
    logic               halted_q, timeout_q, ret_done_q;
    logic [BUS_W-1:0]   host_rdata_q;
    logic               bus_we_q;
    logic [BUS_W-1:0]   bus_addr_q, bus_wdata_q;
    logic [PHASE_W-1:0] phase;
    logic               stopped, run_clr, run_en;

    assign stopped = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign run_clr = stopped && start;
    // An aborted instruction is discarded, so it must not reach the retire wrap.
    assign run_en  = (state_q == ST_RUN) && !abort;

    subleq_phase_tracker #(
        .MAX_INSTR (MAX_INSTR),
        .CNT_W     (CNT_W)
    ) u_phase (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (run_clr),
        .en_i        (run_en),
        .phase_o     (phase),
        .instr_cnt_o (instr_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            core_rst_q   <= 1'b1;
            cpu_en_q     <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            ret_done_q   <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            host_ack_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                        cpu_en_q   <= 1'b1;
                        halted_q   <= 1'b0;
                        timeout_q  <= 1'b0;
                        bus_we_q   <= 1'b0;
                        bus_addr_q <= '0;
                    end else if (host_req) begin
                        state_q     <= ST_HACC;
                        ret_done_q  <= (state_q == ST_DONE);
                        bus_we_q    <= host_we;
                        bus_addr_q  <= host_addr;
                        bus_wdata_q <= host_wdata;
                    end
                end
                ST_HACC: begin
                    if (!bus_we_q)
                        host_rdata_q <= mem_data;
                    host_ack_q <= 1'b1;
                    bus_we_q   <= 1'b0;
                    bus_addr_q <= '0;
                    state_q    <= ST_HACK;
                end
                ST_HACK: begin
                    state_q <= ret_done_q ? ST_DONE : ST_IDLE;
                end
                ST_RUN: begin
                    // Halt wins over abort so a coinciding abort still reports the halt.
                    if ((phase == PHASE_FETCH && mem_addr == HALT_PC) || abort ||
                        (phase == PHASE_LAST && instr_cnt == CNT_W'(MAX_INSTR - 1))) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        core_rst_q <= 1'b1;
                        cpu_en_q   <= 1'b0;
                        if (phase == PHASE_FETCH && mem_addr == HALT_PC)
                            halted_q <= 1'b1;
                        else if (!abort)
                            timeout_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_we   = cpu_en_q ? 1'bz : bus_we_q;
    assign mem_addr = cpu_en_q ? {BUS_W{1'bz}} : bus_addr_q;
    assign mem_data = (!cpu_en_q && bus_we_q) ? bus_wdata_q : {BUS_W{1'bz}};

    assign host_rdata = host_rdata_q;
    assign host_ack   = host_ack_q;
    assign core_rst   = core_rst_q;
    assign cpu_en     = cpu_en_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;
    assign halted     = halted_q;
    assign timeout    = timeout_q;

endmodule
